// File: rtl/comparator_4bit.sv
// Registered one-hot magnitude comparator (G/E/L) with one-cycle latency.
// Optional saturating per-outcome counters are built when COMPARATOR_STATS_EN is defined.
module comparator_4bit #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             G,
    output logic             E,
    output logic             L,
    output logic             out_valid
`ifdef COMPARATOR_STATS_EN
    ,
    output logic [15:0]      count_g,
    output logic [15:0]      count_e,
    output logic [15:0]      count_l
`endif
);

    // Inverting both sign bits maps two's complement ordering onto unsigned ordering.
    function automatic logic [2:0] compare_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] a_k;
        logic [WIDTH-1:0] b_k;
        a_k = a;
        b_k = b;
        if (SIGNED) begin
            a_k[WIDTH-1] = ~a[WIDTH-1];
            b_k[WIDTH-1] = ~b[WIDTH-1];
        end else begin
            a_k = a;
            b_k = b;
        end
        if (a_k > b_k) begin
            return 3'b100;
        end else if (a_k == b_k) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    logic [2:0] result_s;
    logic [2:0] flags_r;
    logic [2:0] flags_next_s;
    logic       out_valid_r;
    logic       out_valid_next_s;

    // Compare the operands as presented this cycle.
    always_comb begin
        result_s = compare_f(A, B);
    end

    // Next-state selection for the result flags and the valid pulse.
    always_comb begin
        flags_next_s     = flags_r;
        out_valid_next_s = 1'b0;
        if (rst) begin
            flags_next_s     = 3'b000;
            out_valid_next_s = 1'b0;
        end else if (in_valid) begin
            flags_next_s     = result_s;
            out_valid_next_s = 1'b1;
        end else begin
            flags_next_s     = flags_r;
            out_valid_next_s = 1'b0;
        end
    end

    // Result register; rst clears it ahead of any sampled pair.
    always_ff @(posedge clk) begin
        flags_r     <= flags_next_s;
        out_valid_r <= out_valid_next_s;
    end

    assign G         = flags_r[2];
    assign E         = flags_r[1];
    assign L         = flags_r[0];
    assign out_valid = out_valid_r;

`ifdef COMPARATOR_STATS_EN
    function automatic logic [15:0] sat_inc_f(input logic [15:0] c);
        if (c == 16'hFFFF) begin
            return c;
        end else begin
            return c + 16'd1;
        end
    endfunction

    logic [15:0] count_g_r;
    logic [15:0] count_e_r;
    logic [15:0] count_l_r;
    logic [15:0] count_g_next_s;
    logic [15:0] count_e_next_s;
    logic [15:0] count_l_next_s;

    // Counters advance on the edge that loads their flag with 1.
    always_comb begin
        count_g_next_s = count_g_r;
        count_e_next_s = count_e_r;
        count_l_next_s = count_l_r;
        if (rst) begin
            count_g_next_s = 16'd0;
            count_e_next_s = 16'd0;
            count_l_next_s = 16'd0;
        end else if (in_valid) begin
            count_g_next_s = result_s[2] ? sat_inc_f(count_g_r) : count_g_r;
            count_e_next_s = result_s[1] ? sat_inc_f(count_e_r) : count_e_r;
            count_l_next_s = result_s[0] ? sat_inc_f(count_l_r) : count_l_r;
        end else begin
            count_g_next_s = count_g_r;
            count_e_next_s = count_e_r;
            count_l_next_s = count_l_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        count_g_r <= count_g_next_s;
        count_e_r <= count_e_next_s;
        count_l_r <= count_l_next_s;
    end

    assign count_g = count_g_r;
    assign count_e = count_e_r;
    assign count_l = count_l_r;
`endif

endmodule

// File: tb/tb_comparator_4bit.sv
// Scoreboard bench for comparator_4bit: an unsigned and a signed instance share stimulus,
// expected flags are queued at issue and popped by a monitor whenever out_valid is high.
module tb_comparator_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       g_u, e_u, l_u, ov_u;
    logic       g_s, e_s, l_s, ov_s;
`ifdef COMPARATOR_STATS_EN
    logic [15:0] cg_u, ce_u, cl_u;
    logic [15:0] cg_s, ce_s, cl_s;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] q_u[$];
    logic [2:0] q_s[$];

    always #5 clk = ~clk;

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .G(g_u), .E(e_u), .L(l_u), .out_valid(ov_u)
`ifdef COMPARATOR_STATS_EN
        , .count_g(cg_u), .count_e(ce_u), .count_l(cl_u)
`endif
    );

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .G(g_s), .E(e_s), .L(l_s), .out_valid(ov_s)
`ifdef COMPARATOR_STATS_EN
        , .count_g(cg_s), .count_e(ce_s), .count_l(cl_s)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever an instance presents a result.
    always @(negedge clk) begin
        if (ov_u === 1'b1) begin
            if (q_u.size() == 0) check("unsigned_unexpected_valid", 32'd1, 32'd0);
            else check("unsigned_flags", {29'd0, g_u, e_u, l_u}, {29'd0, q_u.pop_front()});
        end
        if (ov_s === 1'b1) begin
            if (q_s.size() == 0) check("signed_unexpected_valid", 32'd1, 32'd0);
            else check("signed_flags", {29'd0, g_s, e_s, l_s}, {29'd0, q_s.pop_front()});
        end
    end

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] exp_u, input logic [2:0] exp_s);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        q_u.push_back(exp_u);
        q_s.push_back(exp_s);
        @(posedge clk);
        #1;
    endtask

    // Directed pairs: {A, B, unsigned result, signed result}.
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] eu;
        logic [2:0] es;
    } vec_t;

    vec_t vecs[11] = '{
        '{4'b0000, 4'b0001, LT, LT},
        '{4'b0010, 4'b1000, LT, GT},
        '{4'b0100, 4'b1100, LT, GT},
        '{4'b1000, 4'b0110, GT, LT},
        '{4'b1101, 4'b1010, GT, GT},
        '{4'b1111, 4'b0111, GT, LT},
        '{4'b0000, 4'b0000, EQ, EQ},
        '{4'b0101, 4'b0101, EQ, EQ},
        '{4'b1111, 4'b1111, EQ, EQ},
        '{4'b0000, 4'b1111, LT, GT},
        '{4'b1111, 4'b0000, GT, LT}
    };

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 4'd0;
        B        = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {28'd0, g_u, e_u, l_u, ov_u}, 32'd0);
        check("reset_flags_signed", {28'd0, g_s, e_s, l_s, ov_s}, 32'd0);
`ifdef COMPARATOR_STATS_EN
        check("reset_counts", {cg_u, ce_u | cl_u}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, vecs[i].eu, vecs[i].es);
        in_valid = 1'b0;

        // Hold after a G result (signed instance holds L).
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_unsigned", {28'd0, g_u, e_u, l_u, ov_u}, 32'b1000);
            check("hold_signed", {28'd0, g_s, e_s, l_s, ov_s}, 32'b0010);
        end
`ifdef COMPARATOR_STATS_EN
        check("count_l", {16'd0, cl_u}, 32'd4);
        check("count_g", {16'd0, cg_u}, 32'd4);
        check("count_e", {16'd0, ce_u}, 32'd3);
        check("count_g_signed", {16'd0, cg_s}, 32'd4);
`endif

        // Reset with a valid pair present: the pair must vanish.
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 4'b0000;
        B        = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        check("rst_discard", {28'd0, g_u, e_u, l_u, ov_u}, 32'd0);
        check("rst_discard_signed", {28'd0, g_s, e_s, l_s, ov_s}, 32'd0);
`ifdef COMPARATOR_STATS_EN
        check("rst_counts", {cl_u, cg_u | ce_u}, 32'd0);
`endif
        rst = 1'b0;
        drive(4'b0101, 4'b0011, GT, GT);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
`ifdef COMPARATOR_STATS_EN
        check("post_rst_count_g", {16'd0, cg_u}, 32'd1);
        check("post_rst_count_e", {16'd0, ce_u}, 32'd0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 65540; k++) drive(4'b1010, 4'b1010, EQ, EQ);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("count_e_saturated", {16'd0, ce_u}, 32'h0000FFFF);
        check("count_e_saturated_signed", {16'd0, ce_s}, 32'h0000FFFF);
        check("count_g_after_sat", {16'd0, cg_u}, 32'd0);
`endif

        // Drain scoreboard with a bounded wait.
        for (int t = 0; t < 10 && (q_u.size() != 0 || q_s.size() != 0); t++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", q_u.size() + q_s.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comparator_4bit.md
# comparator_4bit

Registered magnitude comparator for two WIDTH-bit operands, A and B. It produces one-hot greater, equal and less flags one clock after the operands are sampled. It sits in datapath control logic wherever a registered ordering decision is needed, such as threshold checks or min/max selection. It optionally keeps saturating per-outcome event counters for debug.

## Interface
Parameters:
- WIDTH, default 4: operand width in bits; legal range 1 to 32.
- SIGNED, default 0: 0 compares operands as unsigned; 1 compares them as two's complement.

Ports (clock and reset first):
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: when high, A and B are sampled this cycle.
- A, input, WIDTH: first operand.
- B, input, WIDTH: second operand.
- G, output, 1: A > B for the last sampled pair.
- E, output, 1: A == B for the last sampled pair.
- L, output, 1: A < B for the last sampled pair.
- out_valid, output, 1: pulses high for one cycle when G/E/L update.
- count_g, output, 16: number of G results. Present only with COMPARATOR_STATS_EN.
- count_e, output, 16: number of E results. Present only with COMPARATOR_STATS_EN.
- count_l, output, 16: number of L results. Present only with COMPARATOR_STATS_EN.

## Operation
- Comparison rule:
  - SIGNED=0: A and B are unsigned integers.
  - SIGNED=1: the MSB is the sign bit. Example with WIDTH=4: A=4'b1111 (-1) compared with B=4'b0000 gives L.
- Exactly one of G, E, L is high after the first sampled pair. All three are 0 from reset until the first sample.
- Rising edge with in_valid=1 and rst=0:
  - G, E, L load the comparison result of the current A and B.
  - out_valid is set to 1.
- Rising edge with in_valid=0 and rst=0:
  - G, E, L hold their previous values.
  - out_valid is cleared to 0.
- Inputs are not otherwise registered. No combinational path exists from A, B or in_valid to any output.
- There is no backpressure; every cycle with in_valid=1 produces a result.

## Timing
- Latency is 1 cycle: a pair sampled at edge n appears on G/E/L and out_valid right after edge n.
- Throughput is one comparison per cycle.
- Reset values: G=0, E=0, L=0, out_valid=0, and count_g, count_e, count_l = 0.
- rst has priority over in_valid. Asserting rst mid-stream discards the pair sampled that cycle; outputs take reset values at that edge.
- The first in_valid after reset deasserts is sampled normally on that edge.
- A and B may change every cycle. Only their values at the sampling edge matter.

## Configuration
- Macro: COMPARATOR_STATS_EN.
- Defined:
  - count_g, count_e, count_l exist.
  - Each increments on the same edge at which its flag is loaded with 1 under in_valid=1.
  - Each saturates at 16'hFFFF and does not wrap.
  - All three clear on rst.
- Undefined: the count ports and counter logic are absent. G/E/L behaviour is identical in both builds.

## Test plan
- A<B, WIDTH=4, SIGNED=0, in_valid=1: pairs (0000,0001), (0010,1000), (0100,1100) → one cycle later each gives L=1, G=0, E=0, out_valid=1.
- A>B: pairs (1000,0110), (1101,1010), (1111,0111) → G=1, E=0, L=0 on each result cycle.
- A==B: pairs (0000,0000), (0101,0101), (1111,1111) → E=1 only.
- Edge cases, min/max: (0000,1111) → L=1; (1111,0000) → G=1. With SIGNED=1, (1111,0000) → L=1.
- Hold and reset:
  - Drive in_valid=0 for 3 cycles after a G result → G stays 1 and out_valid=0.
  - Assert rst with in_valid=1 → next outputs are all 0 and the pair is not reflected.
- With COMPARATOR_STATS_EN: apply the 11 pairs of the scenarios above (SIGNED=0) → count_l=4, count_g=4, count_e=3. Forcing 65536 E results leaves count_e=16'hFFFF.
